// File: rtl/shift_pkg.sv
// Shared state type and width helpers for the shift serializer controller.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/shift_reg_en.sv
// Serial-in/parallel-out shift register with synchronous clear and shift enable.
module shift_reg_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Clear wins over shift so a fresh word always starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clear)
            q <= '0;
        else if (en)
            q <= {q[WIDTH-2:0], din};
    end

endmodule

// File: rtl/shift_serializer_arb.sv
// Round-robin front end that serializes one requester word at a time, MSB first,
// into a shared shift register and reports the result with a source tag.
module shift_serializer_arb
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       ser_bit,
    output logic                       ser_en,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [idx_width(NREQ)-1:0] out_src,
    output logic                       busy
);

    localparam int SW = idx_width(NREQ);
    localparam int CW = idx_width(WIDTH);
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic [SW-1:0] PTR_INIT = SW'(NREQ - 1);

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  hold;
    logic [SW-1:0]     tag;
    logic [SW-1:0]     ptr;
    logic [SW-1:0]     grant;
    logic [SW-1:0]     cand;
    logic [WIDTH-1:0]  grant_data;
    logic              grant_found;
    logic              accept;
    logic              shift_clear;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = SW'((int'(ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant       = cand;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant == SW'(i))
                grant_data = req_data[i*WIDTH +: WIDTH];
    end

    assign accept  = (state == IDLE) && grant_found;
    assign out_src = tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The grant is combinational, so it is masked while reset is held.
    always_comb begin
        req_ready   = '0;
        ser_en      = 1'b0;
        ser_bit     = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        shift_clear = 1'b0;
        case (state)
            IDLE: begin
                shift_clear = accept;
                if (accept && !reset)
                    req_ready[grant] = 1'b1;
            end
            SHIFT: begin
                ser_en  = 1'b1;
                ser_bit = hold[LAST - cnt];
                busy    = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            hold <= '0;
            tag  <= '0;
            ptr  <= PTR_INIT;
        end else if (accept) begin
            hold <= grant_data;
            tag  <= grant;
            ptr  <= grant;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    shift_reg_en #(.WIDTH(WIDTH)) u_shift (
        .clk   (clk),
        .reset (reset),
        .clear (shift_clear),
        .en    (ser_en),
        .din   (ser_bit),
        .q     (out_data)
    );

endmodule
